// File: rtl/sqrt_pipe_pkg.sv
// Shared definitions for the square-root datapath pipeline blocks:
// segment-width helper and the bit positions of the sideband tag.
package sqrt_pipe_pkg;

  // Tag bit positions carried alongside the operands.
  localparam int TAG_READY = 0;
  localparam int TAG_WR    = 1;
  localparam int TAG_N     = 2;

  // Width of one operand segment when WIDTH is cut into STAGES pieces.
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/split_add_seg.sv
// One stage of the split-carry adder: adds operand segment LOW_W+:SEG_W
// with the incoming carry, appends it to the accumulated low sum and
// forwards the untouched high operand bits to the next stage.
// Vectors on the ports are full operand width; bits this stage neither
// consumes nor produces are ignored on input and zero on output.
module split_add_seg #(
  parameter int SEG_W  = 8,
  parameter int LOW_W  = 0,
  parameter int HIGH_W = 8,
  parameter int TAG_W  = 3,
  localparam int W     = LOW_W + SEG_W + HIGH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     sum_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [W-1:0]     sum_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int OUT_W = LOW_W + SEG_W;

  logic [SEG_W:0]     seg_sum_s;
  logic [OUT_W-1:0]   low_next_s;
  logic               load_s;
  logic               valid_r;
  logic               carry_r;
  logic [OUT_W-1:0]   sum_r;
  logic [TAG_W-1:0]   tag_r;

  // Data registers move only on an advance; a flush leaves them alone.
  assign load_s = en_i & ~flush_i;

  // Segment adder: one SEG_W-bit add with carry-in and carry-out.
  always_comb begin
    seg_sum_s = {1'b0, a_i[LOW_W +: SEG_W]} + {1'b0, b_i[LOW_W +: SEG_W]}
              + {{SEG_W{1'b0}}, carry_i};
  end

  if (LOW_W > 0) begin : g_low
    logic unused_s;
    assign low_next_s = {seg_sum_s[SEG_W-1:0], sum_i[LOW_W-1:0]};
    assign unused_s   = ^{a_i[LOW_W-1:0], b_i[LOW_W-1:0], sum_i[W-1:LOW_W]};
  end else begin : g_nolow
    logic unused_s;
    assign low_next_s = seg_sum_s[SEG_W-1:0];
    assign unused_s   = ^sum_i;
  end

  // Valid bit: flush clears it unconditionally, otherwise follows on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (en_i) begin
      valid_r <= valid_i;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Low sum, carry and tag capture on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= {OUT_W{1'b0}};
      carry_r <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
    end else if (load_s) begin
      sum_r   <= low_next_s;
      carry_r <= seg_sum_s[SEG_W];
      tag_r   <= tag_i;
    end else begin
      sum_r   <= sum_r;
      carry_r <= carry_r;
      tag_r   <= tag_r;
    end
  end

  if (HIGH_W > 0) begin : g_high
    logic [HIGH_W-1:0] a_hi_r;
    logic [HIGH_W-1:0] b_hi_r;

    // Operand bits still waiting for later stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_hi_r <= {HIGH_W{1'b0}};
        b_hi_r <= {HIGH_W{1'b0}};
      end else if (load_s) begin
        a_hi_r <= a_i[W-1 -: HIGH_W];
        b_hi_r <= b_i[W-1 -: HIGH_W];
      end else begin
        a_hi_r <= a_hi_r;
        b_hi_r <= b_hi_r;
      end
    end

    assign a_o   = {a_hi_r, {OUT_W{1'b0}}};
    assign b_o   = {b_hi_r, {OUT_W{1'b0}}};
    assign sum_o = {{HIGH_W{1'b0}}, sum_r};
  end else begin : g_nohigh
    assign a_o   = {W{1'b0}};
    assign b_o   = {W{1'b0}};
    assign sum_o = sum_r;
  end

  assign valid_o = valid_r;
  assign carry_o = carry_r;
  assign tag_o   = tag_r;

endmodule

// File: rtl/pipe_split_adder.sv
// Pipelined split-carry adder/subtractor. The operands are cut into
// STAGES segments; each stage resolves one segment and hands its carry
// to the next. A single global advance stalls the whole pipe when the
// output is held by the consumer.
module pipe_split_adder
  import sqrt_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int SEG_W = seg_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_split_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             adv_s;
  logic [WIDTH-1:0] a_pipe_s     [0:STAGES];
  logic [WIDTH-1:0] b_pipe_s     [0:STAGES];
  logic [WIDTH-1:0] sum_pipe_s   [0:STAGES];
  logic             carry_pipe_s [0:STAGES];
  logic             valid_pipe_s [0:STAGES];
  logic [TAG_W-1:0] tag_pipe_s   [0:STAGES];
  logic             unused_tail_s;

  // The pipe moves whenever the output slot is empty or being consumed;
  // out_ready_i reaches in_ready_o combinationally on purpose.
  assign adv_s      = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv_s;

  // Subtraction is A + ~B + 1, so invert B and inject the carry at entry.
  assign a_pipe_s[0]     = a_i;
  assign b_pipe_s[0]     = sub_i ? ~b_i : b_i;
  assign carry_pipe_s[0] = sub_i;
  assign sum_pipe_s[0]   = {WIDTH{1'b0}};
  assign valid_pipe_s[0] = in_valid_i;
  assign tag_pipe_s[0]   = tag_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    split_add_seg #(
      .SEG_W  (SEG_W),
      .LOW_W  (k * SEG_W),
      .HIGH_W (WIDTH - (k + 1) * SEG_W),
      .TAG_W  (TAG_W)
    ) u_seg (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv_s),
      .flush_i (flush_i),
      .valid_i (valid_pipe_s[k]),
      .carry_i (carry_pipe_s[k]),
      .a_i     (a_pipe_s[k]),
      .b_i     (b_pipe_s[k]),
      .sum_i   (sum_pipe_s[k]),
      .tag_i   (tag_pipe_s[k]),
      .valid_o (valid_pipe_s[k+1]),
      .carry_o (carry_pipe_s[k+1]),
      .a_o     (a_pipe_s[k+1]),
      .b_o     (b_pipe_s[k+1]),
      .sum_o   (sum_pipe_s[k+1]),
      .tag_o   (tag_pipe_s[k+1])
    );
  end

  // The last stage has no operand bits left to forward.
  assign unused_tail_s = ^{a_pipe_s[STAGES], b_pipe_s[STAGES]};

  assign out_valid_o = valid_pipe_s[STAGES];
  assign sum_o       = sum_pipe_s[STAGES];
  assign co_o        = carry_pipe_s[STAGES];
  assign tag_o       = tag_pipe_s[STAGES];

endmodule

// File: tb/tb_pipe_split_adder.sv
// Self-checking bench for pipe_split_adder (WIDTH=16, STAGES=2).
// Expected results are pushed into a scoreboard queue when an input is
// accepted and popped when the DUT hands over a result.
module tb_pipe_split_adder;
  import sqrt_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        sub_i;
  logic [2:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] sum_o;
  logic        co_o;
  logic [2:0]  tag_o;

  logic [19:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  pipe_split_adder #(.WIDTH(16), .STAGES(2), .TAG_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .sub_i       (sub_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .co_o        (co_o),
    .tag_o       (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sum, carry, tag}; in subtract mode carry means "no borrow".
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic [2:0] t);
    logic [16:0] r;
    if (s) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return {r[15:0], r[16], t};
  endfunction

  // One clock cycle starting at a negedge with inputs already driven.
  task automatic cycle(output bit popped, output logic [19:0] obs, output logic [19:0] exp);
    bit acc;
    #1;
    acc    = in_valid_i && in_ready_o && !flush_i;
    popped = out_valid_o && out_ready_i;
    obs    = {sum_o, co_o, tag_o};
    exp    = 'x;
    if (popped && sb_q.size() > 0) exp = sb_q.pop_front();
    if (acc) sb_q.push_back(model(a_i, b_i, sub_i, tag_i));
    @(posedge clk);
    if (flush_i) sb_q.delete();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [2:0] t);
    in_valid_i = v; a_i = a; b_i = b; sub_i = s; tag_i = t;
  endtask

  task automatic test_reset();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    checks++; if (sum_o !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum_o); end
    checks++; if (co_o !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", co_o); end
    checks++; if (tag_o !== 3'b000) begin errors++; $display("FAIL reset_tag: got %b expected 000", tag_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_add_sub();
    logic [15:0] va [6] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h0007, 16'h1234, 16'h8000};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0005, 16'h0FCD, 16'h8000};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit p; logic [19:0] o, e; int lat; logic [2:0] t;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t = (i == 0) ? 3'((1 << TAG_READY) | (1 << TAG_N)) : 3'(i);
      drive(1'b1, va[i], vb[i], vs[i], t);
      cycle(p, o, e);
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
      lat = 0;
      p = 1'b0;
      while (!p && lat < 8) begin lat++; cycle(p, o, e); end
      checks++; if (!p || o !== e) begin errors++; $display("FAIL add_sub[%0d]: got %h expected %h", i, o, e); end
      checks++; if (lat != 2) begin errors++; $display("FAIL latency[%0d]: got %0d expected 2", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    bit p; logic [19:0] o, e; int pops, first, last;
    pops = 0; first = -1; last = -1;
    out_ready_i = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n < 8) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom));
      else drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
      cycle(p, o, e);
      if (p) begin
        pops++;
        if (first < 0) first = n;
        last = n;
        checks++; if (o !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", o, e); end
      end
    end
    checks++; if (pops != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", pops); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_rate: got span %0d expected 7", last - first); end
  endtask

  task automatic test_backpressure();
    logic [15:0] da [4] = '{16'h1111, 16'h2222, 16'hF000, 16'h0ABC};
    logic [15:0] db [4] = '{16'h0001, 16'h3333, 16'h1000, 16'h0CDE};
    bit p; logic [19:0] o, e; int idx, pops, stall_left; bit seen, acc; logic [15:0] held;
    idx = 0; pops = 0; stall_left = 0; seen = 1'b0; held = 16'h0000;
    for (int c = 0; c < 40 && pops < 4; c++) begin
      if (idx < 4) drive(1'b1, da[idx], db[idx], 1'(idx & 1), 3'(idx + 4));
      else drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
      if (!seen && out_valid_o) begin seen = 1'b1; stall_left = 3; held = sum_o; end
      out_ready_i = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b1 || sum_o !== held) begin
          errors++; $display("FAIL stall_hold: got v=%b sum=%h expected v=1 sum=%h", out_valid_o, sum_o, held);
        end
        stall_left--;
      end
      acc = in_valid_i && in_ready_o;
      cycle(p, o, e);
      if (acc) idx++;
      if (p) begin
        pops++;
        checks++; if (o !== e) begin errors++; $display("FAIL bp_data: got %h expected %h", o, e); end
      end
    end
    out_ready_i = 1'b1;
    checks++; if (pops != 4 || !seen) begin errors++; $display("FAIL bp_count: got %0d expected 4", pops); end
  endtask

  task automatic test_flush();
    bit p; logic [19:0] o, e; int lat;
    out_ready_i = 1'b1;
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 3'b001); cycle(p, o, e);
    drive(1'b1, 16'h0303, 16'h0404, 1'b0, 3'b010); cycle(p, o, e);
    // Stall and flush together with a fresh input presented.
    drive(1'b1, 16'h0505, 16'h0606, 1'b0, 3'b011);
    flush_i = 1'b1; out_ready_i = 1'b0;
    cycle(p, o, e);
    flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid[%0d]: got %b expected 0", i, out_valid_o); end
      cycle(p, o, e);
    end
    drive(1'b1, 16'h7F00, 16'h0123, 1'b1, 3'b110); cycle(p, o, e);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    lat = 0; p = 1'b0;
    while (!p && lat < 8) begin lat++; cycle(p, o, e); end
    checks++; if (!p || o !== e || lat != 2) begin
      errors++; $display("FAIL post_flush: got %h lat %0d expected %h lat 2", o, lat, e);
    end
    // Flush with the pipe free to advance: the presented input is dropped.
    drive(1'b1, 16'h4444, 16'h5555, 1'b0, 3'b111);
    flush_i = 1'b1;
    cycle(p, o, e);
    flush_i = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got %b expected 0", i, out_valid_o); end
      cycle(p, o, e);
    end
  endtask

  task automatic test_reset_mid();
    bit p; logic [19:0] o, e; int lat;
    out_ready_i = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 3'b101); cycle(p, o, e);
    drive(1'b1, 16'h4000, 16'h0001, 1'b1, 3'b011); cycle(p, o, e);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    #1;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b expected 1", out_valid_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0 || sum_o !== 16'h0000 || co_o !== 1'b0 || tag_o !== 3'b000) begin
      errors++; $display("FAIL mid_rst_out: got v=%b sum=%h co=%b tag=%b expected all 0", out_valid_o, sum_o, co_o, tag_o);
    end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready_o); end
    sb_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'hABCD, 16'h1234, 1'b0, 3'b100); cycle(p, o, e);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    lat = 0; p = 1'b0;
    while (!p && lat < 8) begin lat++; cycle(p, o, e); end
    checks++; if (!p || o !== e || lat != 2) begin
      errors++; $display("FAIL post_rst: got %h lat %0d expected %h lat 2", o, lat, e);
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_add_sub();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_split_adder.md
# pipe_split_adder

Parametrised, pipelined split-carry adder/subtractor for the square-root datapath. Operands are cut into `STAGES` equal segments. Each pipeline stage adds one segment and registers:
- the accumulated low sum,
- the segment carry,
- the still-unprocessed high operand bits,
- a sideband tag.

It generalises the fixed two-stage, 8-bit-low split adder registers with configurable width and depth, a subtract mode, valid/ready backpressure and a synchronous flush.

## Interface
- `WIDTH`, default 16: operand and result width. Must be divisible by `STAGES`.
- `STAGES`, default 2: number of pipeline stages, which is also the number of segments. Must be ≥1. Segment width `SEG_W = WIDTH/STAGES`.
- `TAG_W`, default 3: sideband width, e.g. ready, write-enable and N flags.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous flush; invalidates every stage.
- `in_valid_i` in 1: input operands valid.
- `in_ready_o` out 1: stage 0 accepts this cycle.
- `a_i` in `WIDTH`: operand A.
- `b_i` in `WIDTH`: operand B.
- `sub_i` in 1: 0 selects A+B; 1 selects A−B.
- `tag_i` in `TAG_W`: sideband, travels with the operands.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `sum_o` out `WIDTH`: result, modulo 2^`WIDTH`.
- `co_o` out 1: final carry. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `tag_o` out `TAG_W`: tag of the result.

## Operation
- **Subtract mode:** at entry, B is replaced by ~B and carry-in is set to `sub_i`. Add mode uses carry-in 0.
- **Stage k (0..STAGES−1):** adds segment k of A and segment k of B plus the incoming carry. It registers:
  - the low sum bits [(k+1)·SEG_W−1:0],
  - the carry out,
  - A and B bits above segment k,
  - the tag,
  - a valid bit.
- **Output:** the last stage drives `sum_o`, `co_o`, `tag_o` and `out_valid_o`.
- **Global advance:** `adv = out_ready_i | ~out_valid_o`.
  - All stage registers load only when `adv` is 1.
  - `in_ready_o = adv`.
  - This is a combinational path from `out_ready_i` to `in_ready_o`, and it is intended.
- **Valid propagation:** on `adv`, stage 0 valid ← `in_valid_i`, and stage k valid ← stage k−1 valid. Bubbles propagate; they are not collapsed.
- **Flush:**
  - On `flush_i`, every valid bit clears at the next edge, regardless of `adv`.
  - Data registers are left unchanged.
  - An input presented in the flush cycle is dropped.
- **Priority:** `rst` > `flush_i` > `adv` > hold.
- **`STAGES=1`:** a single registered full adder.

## Timing
- **Reset:** all valid bits are 0 and all data registers are 0. Therefore `out_valid_o=0`, `sum_o=0`, `co_o=0`, `tag_o=0`, and `in_ready_o=1`.
- **Reset mid-operation:** all in-flight results are lost immediately. There is no partial output.
- **Latency:** `STAGES` cycles from an accepted input (`in_valid_i & in_ready_o`) to `out_valid_o`, when there is no stall.
- **Throughput:** one result per cycle while `out_ready_i=1`.
- **Stall:** when `out_valid_o=1 & out_ready_i=0`, every register holds, and `out_valid_o` and `sum_o` stay stable until accepted.
- **Simultaneous stall and flush:** the flush wins, and `out_valid_o` drops next cycle.

## Structure
- Package `sqrt_pipe_pkg`:
  - function `seg_w(WIDTH, STAGES)`,
  - the tag bit-position constants (`TAG_READY`, `TAG_WR`, `TAG_N`).
- Sub-module `split_add_seg`, one per stage, parametrised by `SEG_W`, `LOW_W`, `HIGH_W`, `TAG_W`:
  - contains the segment adder and the enable-gated stage registers,
  - is instantiated in a generate loop.
- Top level holds the `adv`/flush logic and the subtract pre-inversion.
- Elaboration-time assertion that `WIDTH % STAGES == 0`.

## Test plan
All scenarios use `WIDTH=16, STAGES=2`.
- **Carry across segments:** `a=0x00FF, b=0x0001`, add → 2 cycles later `sum_o=0x0100`, `co_o=0`; the tag is echoed.
- **Overflow:** `a=0xFFFF, b=0x0001`, add → `sum_o=0x0000`, `co_o=1`.
- **Subtract:**
  - `a=0x0005, b=0x0007`, `sub_i=1` → `sum_o=0xFFFE`, `co_o=0`.
  - `a=0x0007, b=0x0005` → `sum_o=0x0002`, `co_o=1`.
- **Backpressure:** stream 4 back-to-back inputs while `out_ready_i=0` for 3 cycles after the first result → `in_ready_o=0` during the stall; all 4 results arrive in order with no loss or duplication.
- **Flush:** assert `flush_i` with 2 results in flight and a new input presented → `out_valid_o` stays 0 for 2 cycles; the next post-flush input emerges after 2 cycles.
- **Reset mid-stream:** pulse `rst` asynchronously between clock edges → outputs are immediately 0 and `out_valid_o=0`; normal operation resumes on the first edge after release.
